// File: rtl/blink_seq_pkg.sv
// blink_seq_pkg: shared states, default period and period clamp for the blink sequencer
package blink_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
    localparam logic [24:0] DEFAULT_PERIOD = 25'd10;
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction
endpackage

// File: rtl/period_cnt.sv
// period_cnt: loadable down-counter with zero flag, load has priority over enable
module period_cnt #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [CNT_W-1:0] count;
    assign zero = (count == '0);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && !zero)
            count <= count - 1'b1;
    end
endmodule

// File: rtl/blink_seq_ctrl.sv
// blink_seq_ctrl: steps an LED through a programmable table of blink periods
module blink_seq_ctrl
    import blink_seq_pkg::*;
#(
    parameter int               CNT_W          = 25,
    parameter int               STEPS          = 4,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(blink_seq_pkg::DEFAULT_PERIOD)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     repeat_en,
    input  logic                     cfg_we,
    input  logic [$clog2(STEPS)-1:0] cfg_addr,
    input  logic [CNT_W-1:0]         cfg_period,
    output logic                     busy,
    output logic                     done,
    output logic                     tick,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     led
);
    localparam int AW = $clog2(STEPS);
    state_t           state, next_state;
    logic [CNT_W-1:0] tbl [STEPS];
    logic [AW-1:0]    sel_idx;
    logic [CNT_W-1:0] load_val;
    logic             cnt_load, zero, step_end, last, advance;
    assign step_end = (state == RUN) && zero;
    assign last     = (step_idx == AW'(STEPS - 1));
    assign advance  = step_end && (!last || repeat_en);
    assign load_val = CNT_W'(clamp_period(32'(tbl[sel_idx])) - 32'd1);
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        sel_idx    = step_idx + AW'(1);
        case (state)
            IDLE: next_state = start ? LOAD : IDLE;
            LOAD: begin
                next_state = RUN;
                cnt_load   = 1'b1;
                sel_idx    = step_idx;
            end
            RUN: begin
                cnt_load   = advance;
                next_state = (step_end && !advance) ? DONE : RUN;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (stop) begin
            next_state = IDLE;
            cnt_load   = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            led      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick     <= 1'b0;
            step_idx <= '0;
            for (int i = 0; i < STEPS; i++) tbl[i] <= DEFAULT_PERIOD;
        end else begin
            state    <= next_state;
            busy     <= (next_state == LOAD) || (next_state == RUN);
            done     <= (state == DONE) && !stop;
            tick     <= step_end && !stop;
            led      <= stop ? 1'b0 : led ^ step_end;
            step_idx <= (stop || (state == IDLE && start)) ? '0 : advance ? step_idx + AW'(1) : step_idx;
            if (cfg_we && (state == IDLE || state == DONE)) tbl[cfg_addr] <= cfg_period;
        end
    end
    period_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(load_val),
        .en      (state == RUN),
        .zero    (zero)
    );
endmodule

// File: tb/tb_blink_seq_ctrl.sv
// tb_blink_seq_ctrl: directed checks of blink_seq_ctrl timing, table, repeat, stop and reset
module tb_blink_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        repeat_en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [24:0] cfg_period = '0;
    logic        busy, done, tick, led;
    logic [1:0]  step_idx;
    int total = 0;
    int bad = 0;
    int tk[$];
    int tl[$];
    int ts[$];
    int dn[$];
    blink_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .repeat_en(repeat_en),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_period(cfg_period),
        .busy(busy), .done(done), .tick(tick), .step_idx(step_idx), .led(led)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask
    task automatic wr(input int a, input int p);
        cfg_we = 1'b1;
        cfg_addr = 2'(a);
        cfg_period = 25'(p);
        step();
        cfg_we = 1'b0;
    endtask
    task automatic watch(input int n);
        tk.delete(); tl.delete(); ts.delete(); dn.delete();
        for (int c = 1; c <= n; c++) begin
            step();
            if (tick) begin
                tk.push_back(c);
                tl.push_back(int'(led));
                ts.push_back(int'(step_idx));
            end
            if (done) dn.push_back(c);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_led"}, led, 0);
        chk({tag, "_step"}, step_idx, 0);
        chk({tag, "_tick"}, tick, 0);
        chk({tag, "_done"}, done, 0);
    endtask
    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        chk_idle("rst");
        pulse_start();
        chk("def_busy", busy, 1);
        watch(45);
        chk("def_nt", tk.size(), 4);
        chk("def_t0", tk[0], 11);
        chk("def_t1", tk[1], 21);
        chk("def_t2", tk[2], 31);
        chk("def_t3", tk[3], 41);
        chk("def_l0", tl[0], 1);
        chk("def_l1", tl[1], 0);
        chk("def_s0", ts[0], 1);
        chk("def_s2", ts[2], 3);
        chk("def_nd", dn.size(), 1);
        chk("def_d", dn[0], 42);
        chk("def_busy_end", busy, 0);
        wr(0, 3); wr(1, 5); wr(2, 2); wr(3, 4);
        pulse_start();
        watch(20);
        chk("tbl_nt", tk.size(), 4);
        chk("tbl_t0", tk[0], 4);
        chk("tbl_t1", tk[1], 9);
        chk("tbl_t2", tk[2], 11);
        chk("tbl_t3", tk[3], 15);
        chk("tbl_s0", ts[0], 1);
        chk("tbl_s1", ts[1], 2);
        chk("tbl_s3", ts[3], 3);
        chk("tbl_d", dn[0], 16);
        chk("tbl_nd", dn.size(), 1);
        repeat_en = 1'b1;
        pulse_start();
        watch(43);
        chk("rep_nt", tk.size(), 12);
        chk("rep_t4", tk[4], 18);
        chk("rep_t8", tk[8], 32);
        chk("rep_t11", tk[11], 43);
        chk("rep_s3", ts[3], 0);
        chk("rep_s11", ts[11], 0);
        chk("rep_nd", dn.size(), 0);
        chk("rep_busy", busy, 1);
        repeat_en = 1'b0;
        watch(20);
        chk("rep_off_t0", tk[0], 3);
        chk("rep_off_t3", tk[3], 14);
        chk("rep_off_nt", tk.size(), 4);
        chk("rep_off_d", dn[0], 15);
        pulse_start();
        watch(6);
        chk("stp1_led", led, 1);
        chk("stp1_step", step_idx, 1);
        pulse_stop();
        chk_idle("stp1");
        pulse_start();
        watch(10);
        chk("stp2_step", step_idx, 2);
        pulse_stop();
        chk_idle("stp2");
        watch(20);
        chk("stp2_nt", tk.size(), 0);
        chk("stp2_nd", dn.size(), 0);
        pulse_start();
        watch(20);
        chk("rst_t0", tk[0], 4);
        chk("rst_t3", tk[3], 15);
        chk("rst_d", dn[0], 16);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy", busy, 0);
        watch(15);
        chk("ss_nt", tk.size(), 0);
        wr(0, 0);
        pulse_start();
        watch(14);
        chk("p0_t0", tk[0], 2);
        chk("p0_t1", tk[1], 7);
        chk("p0_t3", tk[3], 13);
        chk("p0_d", dn[0], 14);
        pulse_start();
        step();
        wr(1, 7);
        watch(20);
        pulse_start();
        watch(15);
        chk("we_run_t1", tk[1], 7);
        chk("we_run_t3", tk[3], 13);
        pulse_start();
        watch(3);
        chk("mid_led", led, 1);
        rst = 1'b1;
        step();
        chk_idle("mid_rst");
        rst = 1'b0;
        pulse_start();
        watch(45);
        chk("mid_t0", tk[0], 11);
        chk("mid_t1", tk[1], 21);
        chk("mid_d", dn[0], 42);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
